// File: rtl/serialparalelo_align.sv
// Serial-to-parallel converter that aligns code-group boundaries to K28.5 commas
// and emits aligned words once enough aligned commas have been seen.
//
// state   | meaning
// SEARCH  | hunting for any comma, bit counter ignored
// ACQUIRE | boundary fixed by last comma, counting aligned commas towards lock
// LOCKED  | emitting aligned words, counting misaligned commas towards loss
module serialparalelo_align #(
    parameter int             W        = 10,
    parameter logic [W-1:0]   COMMA_N  = 10'b0011111010,
    parameter logic [W-1:0]   COMMA_P  = 10'b1100000101,
    parameter int             LOCK_CNT = 3,
    parameter int             LOSS_CNT = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         ENB,
    input  logic         in_serial,
    output logic [W-1:0] out_paralelo,
    output logic         valid,
    output logic         comma_det,
    output logic         locked
);

    localparam int CW = $clog2(W);
    localparam int KW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(LOSS_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
    localparam logic [KW-1:0] LOCK_V  = KW'(LOCK_CNT);
    localparam logic [EW-1:0] LOSS_V  = EW'(LOSS_CNT);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t        state;
    logic [W-2:0]  sr;
    logic [CW-1:0] cnt;
    logic [KW-1:0] comma_cnt;
    logic [EW-1:0] err_cnt;

    logic [W-1:0]  nxt;
    logic          is_comma;
    logic          boundary;
    logic [CW-1:0] cnt_inc;
    logic [KW-1:0] comma_inc;
    logic [EW-1:0] err_inc;

    // Only W-1 history bits are kept: the oldest bit falls out when nxt forms.
    assign nxt       = {sr, in_serial};
    assign is_comma  = (nxt == COMMA_N) || (nxt == COMMA_P);
    assign boundary  = (cnt == CNT_MAX);
    assign cnt_inc   = boundary ? '0 : cnt + 1'b1;
    assign comma_inc = comma_cnt + 1'b1;
    assign err_inc   = err_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= SEARCH;
            sr           <= '0;
            cnt          <= '0;
            comma_cnt    <= '0;
            err_cnt      <= '0;
            out_paralelo <= '0;
            valid        <= 1'b0;
            comma_det    <= 1'b0;
            locked       <= 1'b0;
        end else if (ENB) begin
            sr    <= nxt[W-2:0];
            valid <= 1'b0;
            cnt   <= cnt_inc;
            case (state)
                SEARCH: begin
                    if (is_comma) begin
                        cnt       <= '0;
                        comma_cnt <= KW'(1);
                        if (LOCK_CNT == 1) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            err_cnt <= '0;
                        end else begin
                            state <= ACQUIRE;
                        end
                    end
                end
                ACQUIRE: begin
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt <= comma_inc;
                            if (comma_inc == LOCK_V) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                err_cnt <= '0;
                            end
                        end
                    end else if (is_comma) begin
                        cnt       <= '0;
                        comma_cnt <= KW'(1);
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        out_paralelo <= nxt;
                        valid        <= 1'b1;
                        comma_det    <= is_comma;
                        if (is_comma) err_cnt <= '0;
                    end else if (is_comma) begin
                        // Misaligned comma: alignment is kept, only the loss counter moves.
                        if (err_inc == LOSS_V) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            err_cnt   <= '0;
                            comma_cnt <= '0;
                        end else begin
                            err_cnt <= err_inc;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_serialparalelo_align.sv
// Directed bench for serialparalelo_align: stimulus pushes expected words into a
// scoreboard queue, a monitor pops and compares on every fresh valid strobe.
module tb_serialparalelo_align;

    localparam logic [9:0] CN  = 10'b0011111010;
    localparam logic [9:0] CP  = 10'b1100000101;
    localparam logic [9:0] D21 = 10'b1010101010;
    localparam logic [9:0] WA  = 10'b0110001011;
    localparam logic [9:0] WB  = 10'b1001110100;
    localparam logic [9:0] MW1 = 10'b1000111110;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       ENB = 1'b0;
    logic       in_serial = 1'b0;
    logic [9:0] out_paralelo;
    logic       valid;
    logic       comma_det;
    logic       locked;

    int checks = 0;
    int failures = 0;
    logic en_q = 1'b0;
    logic [10:0] exp_q[$];

    serialparalelo_align dut (
        .CLK(CLK),
        .reset(reset),
        .ENB(ENB),
        .in_serial(in_serial),
        .out_paralelo(out_paralelo),
        .valid(valid),
        .comma_det(comma_det),
        .locked(locked)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge CLK) en_q <= ENB && !reset;

    // A valid counts once: only when the edge that produced it was enabled.
    always @(negedge CLK) begin
        if (en_q && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got word %b, expected no strobe at %0t", out_paralelo, $time);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("sb_word", 32'(out_paralelo), 32'(e[9:0]));
                check("sb_comma_det", 32'(comma_det), 32'(e[10]));
            end
        end
    end

    task automatic send_bit(input logic b);
        in_serial = b;
        ENB = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic push_exp(input logic [9:0] w, input logic cd);
        exp_q.push_back({cd, w});
    endtask

    // Two words carrying a comma shifted two bits past the boundary.
    task automatic mis_chunk();
        push_exp(MW1, 1'b0);
        push_exp(D21, 1'b0);
        send_word(MW1);
        send_word(D21);
    endtask

    initial begin
        // reset and idle zeros
        reset = 1'b1;
        ENB = 1'b1;
        in_serial = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_comma_det", 32'(comma_det), 0);
        check("rst_out", 32'(out_paralelo), 0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) send_bit(1'b0);
        check("idle_locked", 32'(locked), 0);
        check("idle_out", 32'(out_paralelo), 0);

        // lock acquisition
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(CN);
        send_word(D21);
        send_word(CP);
        send_word(D21);
        for (int i = 9; i >= 1; i--) send_bit(CN[i]);
        check("lock_not_yet", 32'(locked), 0);
        send_bit(CN[0]);
        check("lock_rise", 32'(locked), 1);
        push_exp(WA, 1'b0);
        send_word(WA);

        // three misaligned commas then an aligned one: lock held, errors cleared
        for (int k = 0; k < 3; k++) mis_chunk();
        check("hold_after_3_mis", 32'(locked), 1);
        push_exp(CN, 1'b1);
        send_word(CN);
        for (int k = 0; k < 3; k++) mis_chunk();
        check("hold_after_clear", 32'(locked), 1);
        push_exp(CN, 1'b1);
        send_word(CN);

        // four misaligned commas: loss of lock after the fourth
        for (int k = 0; k < 3; k++) mis_chunk();
        push_exp(MW1, 1'b0);
        send_word(MW1);
        send_bit(1'b1);
        check("loss_not_yet", 32'(locked), 1);
        send_bit(1'b0);
        check("loss_fall", 32'(locked), 0);
        for (int i = 7; i >= 0; i--) send_bit(D21[i]);
        check("loss_out_kept", 32'(out_paralelo), 32'(MW1));

        // realign in ACQUIRE: one extra bit shifts the boundary
        send_word(CN);
        send_bit(1'b1);
        send_word(CP);
        send_word(CN);
        check("realign_count2", 32'(locked), 0);
        send_word(D21);
        for (int i = 9; i >= 1; i--) send_bit(CP[i]);
        check("realign_not_yet", 32'(locked), 0);
        send_bit(CP[0]);
        check("realign_lock", 32'(locked), 1);
        push_exp(WA, 1'b0);
        send_word(WA);
        push_exp(CN, 1'b1);
        send_word(CN);

        // ENB stall mid-word, then stall right after a strobe
        push_exp(WB, 1'b0);
        for (int i = 9; i >= 6; i--) send_bit(WB[i]);
        for (int s = 0; s < 5; s++) begin
            in_serial = ~in_serial;
            ENB = 1'b0;
            @(posedge CLK);
            #1;
            check("stall_mid_valid", 32'(valid), 0);
        end
        for (int i = 5; i >= 0; i--) send_bit(WB[i]);
        for (int s = 0; s < 3; s++) begin
            in_serial = ~in_serial;
            ENB = 1'b0;
            @(posedge CLK);
            #1;
            check("stall_held_valid", 32'(valid), 1);
            check("stall_held_out", 32'(out_paralelo), 32'(WB));
        end
        push_exp(D21, 1'b0);
        send_word(D21);

        // reset mid-lock
        for (int i = 9; i >= 6; i--) send_bit(WA[i]);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        check("rst_mid_locked", 32'(locked), 0);
        check("rst_mid_valid", 32'(valid), 0);
        check("rst_mid_out", 32'(out_paralelo), 0);
        send_word(CN);
        send_word(D21);
        send_word(CP);
        send_word(D21);
        check("relock_not_yet", 32'(locked), 0);
        send_word(CN);
        check("relock", 32'(locked), 1);
        push_exp(WA, 1'b0);
        send_word(WA);
        send_bit(1'b1);
        send_bit(1'b0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serialparalelo_align.md
Name: serialparalelo_align

Overview:
Parametrised serial-to-parallel converter with comma-based word alignment. It is the receive-side successor to the fixed 10-bit deserializer in the 8b/10b PHY chain. It hunts the serial stream for K28.5 commas (either running disparity) and aligns word boundaries to them. After a configurable number of aligned commas it declares lock and then emits aligned W-bit words to the decoder.

Parameters:
W, 10, code-group width in bits (W >= 4)
COMMA_N, 10'b0011111010, comma pattern, RD- (K28.5), W bits, MSB = first bit on the wire
COMMA_P, 10'b1100000101, comma pattern, RD+ (K28.5), W bits
LOCK_CNT, 3, aligned commas needed to enter LOCKED (>= 1)
LOSS_CNT, 4, consecutive misaligned commas in LOCKED that force re-search (>= 1)

Ports:
CLK  input  1  bit clock; one serial bit per rising edge
reset  input  1  synchronous, active-high reset
ENB  input  1  bit enable; when low, all state and outputs hold
in_serial  input  1  serial data, MSB of each code group first
out_paralelo  output  W  last aligned code group; first received bit in [W-1]
valid  output  1  one-cycle strobe: out_paralelo updated with a new word (LOCKED only)
comma_det  output  1  qualifies valid: the word just emitted equals COMMA_N or COMMA_P
locked  output  1  high while in LOCKED

Behaviour:
- All state is registered on the rising edge of CLK. Reset has priority over ENB.
- Reset values: out_paralelo = 0, valid = 0, comma_det = 0, locked = 0, shift register = 0, bit counter = 0, comma count = 0, error count = 0, state = SEARCH.
- With ENB = 0 nothing changes, including valid (a held strobe stays held).
- Define nxt = {sr[W-2:0], in_serial} on every enabled edge; sr <= nxt. is_comma = (nxt == COMMA_N) || (nxt == COMMA_P).
- Bit counter cnt runs 0..W-1 and wraps to 0. An edge with cnt == W-1 is a "boundary" edge: nxt is a complete aligned word.
- valid defaults to 0 on every enabled edge unless set below. comma_det is updated only when valid is set.
- SEARCH: cnt is ignored.
  - When is_comma: cnt <= 0 and comma count <= 1.
  - If LOCK_CNT == 1, go to LOCKED. Otherwise go to ACQUIRE.
- ACQUIRE:
  - Boundary edge with is_comma: increment comma count. If it reaches LOCK_CNT, go to LOCKED (locked = 1 from the next cycle) and clear the error count.
  - Boundary edge without a comma: no change; data between commas is allowed.
  - Non-boundary edge with is_comma: realign. cnt <= 0, comma count <= 1, stay in ACQUIRE.
  - No valid strobes are issued in ACQUIRE.
- LOCKED:
  - Every boundary edge: out_paralelo <= nxt, valid <= 1, comma_det <= is_comma.
  - Boundary edge with a comma: clear the error count.
  - Non-boundary edge with is_comma: increment the error count; alignment is NOT changed. If the count reaches LOSS_CNT, go to SEARCH with locked <= 0, error count <= 0, comma count <= 0.
  - out_paralelo keeps its last value after loss of lock.
- Latency: valid and out_paralelo appear in the cycle after the edge that samples the word's last bit.
- Priority: on any one edge only one of boundary / non-boundary applies, so there are no simultaneous-event conflicts.
- Reset mid-word or mid-lock discards the partial word and returns to SEARCH on that edge.

Test Plan:
- Reset then idle zeros: reset = 1 for 2 cycles, ENB = 1, in_serial = 0 for 50 bits -> locked = 0, valid never asserts, out_paralelo = 0.
- Lock acquisition: send 3 bits of junk, then COMMA_N, D21.5 (1010101010), COMMA_P, D21.5, COMMA_N -> locked rises the cycle after the third comma's last bit. The next word 0110001011 yields valid = 1, out_paralelo = 10'b0110001011, comma_det = 0.
- Realign in ACQUIRE: after the first comma, insert 1 extra bit before the next comma -> comma count restarts at 1. Lock requires 3 commas counted from the shifted alignment.
- Loss of lock: once LOCKED, inject 4 commas each offset by 2 bits with no aligned comma between them -> locked falls after the 4th. With only 3 misaligned commas then 1 aligned comma, lock is held and the error count is cleared.
- ENB gating: in LOCKED, drop ENB for 5 cycles mid-word while in_serial toggles -> the word received after ENB returns is identical to the no-stall run, and valid does not repeat during the stall.
- Reset mid-lock: assert reset for 1 cycle while locked = 1 -> the next cycle shows locked = 0, valid = 0, out_paralelo = 0, and reacquisition needs 3 fresh commas.
